hazard_controller: RTL

Central stall/flush/forward sequencer for the five-stage pipeline. It drives the hold (EN) and clear (CLR) inputs of every inter-stage register, including the fetch-to-decode register, and the forwarding mux selects in Decode and Execute. It resolves load-use, branch-compare and data-memory-wait hazards. A registered state machine freezes the pipeline while the data memory is not ready and flags wait timeouts.

---
 rtl/mips_pkg.sv | 8 +
 rtl/forward_unit.sv | 27 ++
 rtl/hazard_controller.sv | 89 ++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared pipeline widths, forward-select encodings and hazard FSM states
package mips_pkg;
  localparam int REG_ADDR_W = 5;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_WB = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  typedef enum logic {ST_RUN = 1'b0, ST_MEM_WAIT = 1'b1} state_t;
endpackage

// File: rtl/forward_unit.sv
// forward_unit: combinational Decode/Execute forwarding selects from M/W destination matches
module forward_unit #(
  parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] RsD,
  input  logic [REG_ADDR_W-1:0] RtD,
  input  logic [REG_ADDR_W-1:0] RsE,
  input  logic [REG_ADDR_W-1:0] RtE,
  input  logic [REG_ADDR_W-1:0] WriteRegM,
  input  logic [REG_ADDR_W-1:0] WriteRegW,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  output logic                  ForwardAD,
  output logic                  ForwardBD,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE
);
  import mips_pkg::*;
  always_comb begin
    ForwardAD = RsD != '0 && RsD == WriteRegM && RegWriteM;
    ForwardBD = RtD != '0 && RtD == WriteRegM && RegWriteM;
    ForwardAE = (RsE != '0 && RsE == WriteRegM && RegWriteM) ? FWD_MEM :
                (RsE != '0 && RsE == WriteRegW && RegWriteW) ? FWD_WB : FWD_RF;
    ForwardBE = (RtE != '0 && RtE == WriteRegM && RegWriteM) ? FWD_MEM :
                (RtE != '0 && RtE == WriteRegW && RegWriteW) ? FWD_WB : FWD_RF;
  end
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: pipeline stall/flush/forward sequencer with memory-wait FSM, timeout flag and stall statistics
module hazard_controller #(
  parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W,
  parameter int WAIT_CNT_W = 8,
  parameter int WAIT_LIMIT = 200
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [REG_ADDR_W-1:0] RsD,
  input  logic [REG_ADDR_W-1:0] RtD,
  input  logic [REG_ADDR_W-1:0] RsE,
  input  logic [REG_ADDR_W-1:0] RtE,
  input  logic [REG_ADDR_W-1:0] WriteRegE,
  input  logic [REG_ADDR_W-1:0] WriteRegM,
  input  logic [REG_ADDR_W-1:0] WriteRegW,
  input  logic                  RegWriteE,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  MemtoRegE,
  input  logic                  MemtoRegM,
  input  logic                  BranchD,
  input  logic                  JumpD,
  input  logic                  PCSrcD,
  input  logic                  MemReqM,
  input  logic                  MemReadyM,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushW,
  output logic                  ForwardAD,
  output logic                  ForwardBD,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  MemTimeout,
  output logic [WAIT_CNT_W-1:0] StallCount
);
  import mips_pkg::*;
  state_t state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d, stall_cnt_q, stall_cnt_d;
  logic timeout_q, timeout_d;
  logic mem_miss, memwait, lwstall, brstall, hz_stall;
  forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd (
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE)
  );
  always_comb begin
    mem_miss = MemReqM && !MemReadyM;
    memwait = state_q == ST_MEM_WAIT || mem_miss;
    lwstall = MemtoRegE && RtE != '0 && (RtE == RsD || RtE == RtD);
    brstall = BranchD &&
              ((RegWriteE && WriteRegE != '0 && (WriteRegE == RsD || WriteRegE == RtD)) ||
               (MemtoRegM && WriteRegM != '0 && (WriteRegM == RsD || WriteRegM == RtD)));
    hz_stall = !memwait && (lwstall || brstall);
    StallF = RST && (memwait || hz_stall);
    StallD = RST && (memwait || hz_stall);
    StallE = RST && memwait;
    StallM = RST && memwait;
    FlushW = RST && memwait;
    FlushE = RST && hz_stall;
    FlushD = RST && !memwait && !lwstall && !brstall && (PCSrcD || JumpD);
    state_d = (state_q == ST_RUN) ? (mem_miss ? ST_MEM_WAIT : ST_RUN) :
              (MemReadyM ? ST_RUN : ST_MEM_WAIT);
    wait_cnt_d = (state_q == ST_RUN && mem_miss) ? '0 :
                 (state_q == ST_MEM_WAIT && wait_cnt_q != '1) ? wait_cnt_q + 1'b1 : wait_cnt_q;
    timeout_d = timeout_q || (state_q == ST_MEM_WAIT && wait_cnt_d == WAIT_CNT_W'(WAIT_LIMIT));
    stall_cnt_d = (StallF && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_RUN;
      wait_cnt_q <= '0;
      timeout_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign MemTimeout = timeout_q;
  assign StallCount = stall_cnt_q;
endmodule
